simon_round_ctrl: RTL and testbench

Round sequencer for the Simon Says game: generates a growing random colour sequence, plays it back on the four LEDs with tick-based on/off timing, checks the player's button presses against it, and declares win or lose. It sits between the button synchronizer/edge-detect front end and the LED pins. It replaces the fixed five-entry pattern with an LFSR-built pattern of up to MAX_LEN entries, and uses the clock-divider output as a one-cycle enable rather than as a clock.

---
 rtl/simon_round_ctrl_if.sv | 25 ++
 rtl/simon_round_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_simon_round_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_round_ctrl_if.sv
// Simon round controller bus: game inputs (tick, start, presses) and display outputs.
// Latency: none, this is a wiring bundle only.
// Backpressure: none; every signal is a level or a one-cycle pulse with no handshake.
// Ports: tick/start/btn_press flow master->slave; leds, correct_led, wrong_led,
//        level and state_o flow slave->master.
interface simon_round_ctrl_if;
  logic       tick;         // one-cycle enable from the clock divider
  logic       start;        // one-cycle start / acknowledge pulse
  logic [3:0] btn_press;    // one-cycle press pulses, bit0=A .. bit3=D
  logic [3:0] leds;         // game LEDs
  logic       correct_led;  // high in WIN
  logic       wrong_led;    // high in LOSE
  logic [3:0] level;        // current sequence length
  logic [2:0] state_o;      // state encoding for debug

  modport master (
    output tick, start, btn_press,
    input  leds, correct_led, wrong_led, level, state_o
  );

  modport slave (
    input  tick, start, btn_press,
    output leds, correct_led, wrong_led, level, state_o
  );
endinterface

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: grows an LFSR pattern, plays it on the LEDs, checks presses.
// Latency: outputs are registered and reflect the state entered on the previous clk edge.
// Backpressure: none; start/btn_press are ignored in GEN/SHOW states, tick is a plain enable.
// Ports: clk, reset_n (sync, active-low); bus (slave modport) carries tick, start,
//        btn_press in and leds, correct_led, wrong_led, level, state_o out.
module simon_round_ctrl #(
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned ON_TICKS      = 2,
  parameter int unsigned OFF_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  simon_round_ctrl_if.slave bus
);

  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_MAX = (ON_TICKS > OFF_TICKS)
                           ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                           : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]       LEN_MAX  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [1:0]       mem_q [MAX_LEN];
  logic             mem_we;

  logic [3:0]       leds_q, leds_d;
  logic             correct_q, correct_d;
  logic             wrong_q, wrong_d;

  logic             any_press;
  logic             press_onehot;
  logic [3:0]       expected_btn;
  logic             last_elem;
  logic [1:0]       next_sym;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    any_press    = |bus.btn_press;
    // clearing the lowest set bit leaves zero only for a single set bit
    press_onehot = any_press && ((bus.btn_press & (bus.btn_press - 4'd1)) == 4'd0);
    expected_btn = 4'b0001 << mem_q[idx_q];
    last_elem    = (4'(idx_q) == (len_q - 4'd1));

    case (state_q)
      S_IDLE: begin
        if (bus.start || any_press) begin
          len_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_GEN;
        end
      end

      S_GEN: begin
        mem_we  = 1'b1;
        len_d   = len_q + 4'd1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW_ON;
      end

      S_SHOW_ON: begin
        if (bus.tick) begin
          if (cnt_q == ON_LAST) begin
            cnt_d   = '0;
            state_d = S_SHOW_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_SHOW_OFF: begin
        if (bus.tick) begin
          if (cnt_q == OFF_LAST) begin
            cnt_d = '0;
            if (last_elem) begin
              idx_d   = '0;
              state_d = S_WAIT_IN;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SHOW_ON;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WAIT_IN: begin
        // a press always wins over a coincident tick
        if (any_press) begin
          cnt_d = '0;
          if (press_onehot && (bus.btn_press == expected_btn)) begin
            if (last_elem) begin
              state_d = (len_q == LEN_MAX) ? S_WIN : S_GEN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (bus.tick) begin
          if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            state_d = S_LOSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (bus.start || any_press) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Symbol shown next cycle; on GEN->SHOW_ON with an empty pattern the entry
    // is being written on this same edge, so take it straight from the LFSR.
    if ((state_q == S_GEN) && (idx_d == len_q[IDX_W-1:0])) begin
      next_sym = lfsr_q[1:0];
    end else begin
      next_sym = mem_q[idx_d];
    end

    case (state_d)
      S_IDLE, S_WIN: leds_d = 4'b1111;
      S_SHOW_ON:     leds_d = 4'b0001 << next_sym;
      default:       leds_d = 4'b0000;
    endcase
    correct_d = (state_d == S_WIN);
    wrong_d   = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= 4'd0;
      idx_q     <= '0;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      leds_q    <= 4'b1111;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      leds_q    <= leds_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      // pattern storage holds no reset value; entries at or above len are never read
      if (mem_we) begin
        mem_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
      end
    end
  end

  assign bus.leds        = leds_q;
  assign bus.correct_led = correct_q;
  assign bus.wrong_led   = wrong_q;
  assign bus.level       = len_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl with a behavioural game model.
// Latency: model follows the DUT one clk edge at a time; outputs compared on negedge.
// Backpressure: none; the bench player drives presses from the model's view of the game.
module tb_simon_round_ctrl;
  localparam int MAXL = 3;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int TOT  = 4;

  logic clk;
  logic reset_n;
  int   errs   = 0;
  int   checks = 0;
  bit   chk_en = 0;
  int   tick_ph = 0;

  simon_round_ctrl_if bus_if();

  simon_round_ctrl #(
    .MAX_LEN(MAXL), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
    .TIMEOUT_TICKS(TOT), .SEED(8'hA5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tick on every 4th clk
  always @(posedge clk) begin
    #1;
    tick_ph     = (tick_ph == 3) ? 0 : tick_ph + 1;
    bus_if.tick = (tick_ph == 3);
  end

  // ---------------- behavioural game model ----------------
  int         m_state = 0;   // 0 idle,1 gen,2 show on,3 show off,4 wait,5 win,6 lose
  int         m_len   = 0;
  int         m_idx   = 0;
  int         m_cnt   = 0;
  logic [7:0] m_lfsr  = 8'hA5;
  int         m_pat [16];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int ones(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  always @(posedge clk) begin
    logic [7:0] cur;
    logic [3:0] b;
    cur    = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    b      = bus_if.btn_press;
    if (!reset_n) begin
      m_state = 0; m_len = 0; m_idx = 0; m_cnt = 0; m_lfsr = 8'hA5;
    end else if (m_state == 0) begin
      if (bus_if.start || b != 0) begin m_len = 0; m_state = 1; m_cnt = 0; end
    end else if (m_state == 1) begin
      m_pat[m_len] = int'(cur[1:0]);
      m_len++; m_idx = 0; m_state = 2; m_cnt = 0;
    end else if (m_state == 2 || m_state == 3) begin
      if (bus_if.tick) begin
        m_cnt++;
        if (m_state == 2 && m_cnt == ONT) begin
          m_state = 3; m_cnt = 0;
        end else if (m_state == 3 && m_cnt == OFFT) begin
          m_cnt = 0;
          if (m_idx == m_len - 1) begin m_idx = 0; m_state = 4; end
          else begin m_idx++; m_state = 2; end
        end
      end
    end else if (m_state == 4) begin
      if (b != 0) begin
        m_cnt = 0;
        if (ones(b) == 1 && b == (4'd1 << m_pat[m_idx])) begin
          if (m_idx == m_len - 1) m_state = (m_len == MAXL) ? 5 : 1;
          else m_idx++;
        end else begin
          m_state = 6;
        end
      end else if (bus_if.tick) begin
        m_cnt++;
        if (m_cnt == TOT) begin m_state = 6; m_cnt = 0; end
      end
    end else begin
      if (bus_if.start || b != 0) begin m_state = 0; m_cnt = 0; end
    end
  end

  function automatic logic [3:0] exp_leds();
    if (m_state == 0 || m_state == 5) return 4'b1111;
    if (m_state == 2) return 4'b0001 << m_pat[m_idx];
    return 4'b0000;
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus_if.leds !== exp_leds() || bus_if.state_o !== 3'(m_state) ||
          bus_if.level !== 4'(m_len) || bus_if.correct_led !== (m_state == 5) ||
          bus_if.wrong_led !== (m_state == 6)) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t got leds=%b st=%0d lvl=%0d c=%b w=%b want leds=%b st=%0d lvl=%0d",
                 $time, bus_if.leds, bus_if.state_o, bus_if.level, bus_if.correct_led,
                 bus_if.wrong_led, exp_leds(), m_state, m_len);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // begin a game: 0 start, 1 press, 2 both in the same cycle
  task automatic begin_game(input int how);
    @(posedge clk); #2;
    bus_if.start     = (how != 1);
    bus_if.btn_press = (how != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
    @(posedge clk); #2;
    bus_if.start = 1'b0; bus_if.btn_press = 4'd0;
  endtask

  // acknowledge WIN/LOSE and confirm the same pulse does not start a new game
  task automatic ack(input bit use_btn, input string name);
    @(posedge clk); #2;
    if (use_btn) bus_if.btn_press = 4'($urandom_range(1, 15));
    else         bus_if.start = 1'b1;
    @(posedge clk); #2;
    bus_if.start = 1'b0; bus_if.btn_press = 4'd0;
    @(negedge clk); chk({name, "_idle"}, 32'(bus_if.state_o), 0);
    @(negedge clk); chk({name, "_stay"}, 32'(bus_if.state_o), 0);
  endtask

  // play until WIN/LOSE; kind: 0 wrong one-hot, 1 multi-hot, 2 timeout, 3 press on timeout tick
  task automatic run_game(input int bad_round, input int bad_idx, input int kind, input bit noise);
    int  w, d, n, c;
    bit  special;
    w = 0; d = $urandom_range(0, 8); n = 0;
    while (!(m_state == 5 || m_state == 6) && n < 3000) begin
      @(posedge clk); #2;
      n++;
      bus_if.start = 1'b0; bus_if.btn_press = 4'd0;
      if (m_state == 4) begin
        c       = m_pat[m_idx];
        special = (m_len == bad_round) && (kind == 3 || m_idx == bad_idx);
        if (special && kind == 0)
          bus_if.btn_press = 4'(1 << ((c + $urandom_range(1, 3)) % 4));
        else if (special && kind == 1)
          bus_if.btn_press = 4'b0011;
        else if (special && kind == 3) begin
          if (m_cnt == TOT - 1 && bus_if.tick) bus_if.btn_press = 4'(1 << c);
        end else if (!special) begin
          if (w >= d) begin bus_if.btn_press = 4'(1 << c); w = 0; d = $urandom_range(0, 8); end
          else w++;
        end
      end else if (noise && (m_state == 1 || m_state == 2 || m_state == 3)) begin
        bus_if.start     = ($urandom_range(0, 5) == 0);
        bus_if.btn_press = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
    end
    bus_if.start = 1'b0; bus_if.btn_press = 4'd0;
    if (n >= 3000) begin
      errs++;
      $display("FAIL game_budget got=running want=WIN_or_LOSE t=%0t", $time);
    end
  endtask

  initial begin
    int on_t, off_t, n, kind;
    reset_n = 1'b0;
    bus_if.tick = 1'b0; bus_if.start = 1'b0; bus_if.btn_press = 4'd0;

    // reset and idle
    @(posedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_leds", 32'(bus_if.leds), 32'hF);
    chk("rst_level", 32'(bus_if.level), 0);
    chk("rst_state", 32'(bus_if.state_o), 0);
    chk("rst_status", {30'd0, bus_if.correct_led, bus_if.wrong_led}, 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);
    @(negedge clk);
    chk("lfsr_step1", 32'(dut.lfsr_q), 32'h4A);
    chk("model_lfsr1", 32'(m_lfsr), 32'h4A);
    @(negedge clk);
    chk("lfsr_step2", 32'(dut.lfsr_q), 32'h95);
    repeat (20) @(negedge clk);
    chk("idle_state", 32'(bus_if.state_o), 0);
    chk("idle_leds", 32'(bus_if.leds), 32'hF);

    // playback timing, then a full win
    begin_game(0);
    @(negedge clk); chk("start_gen", 32'(bus_if.state_o), 1);
    @(negedge clk); chk("show_on", 32'(bus_if.state_o), 2);
    chk("show_onehot", 32'(ones(bus_if.leds)), 1);
    on_t = 0; off_t = 0; n = 0;
    while (bus_if.state_o != 3'd4 && n < 200) begin
      if (bus_if.state_o == 3'd2 && bus_if.tick) on_t++;
      if (bus_if.state_o == 3'd3 && bus_if.tick) off_t++;
      @(negedge clk); n++;
    end
    chk("on_ticks", 32'(on_t), ONT);
    chk("off_ticks", 32'(off_t), OFFT);
    chk("wait_level", 32'(bus_if.level), 1);
    run_game(0, 0, 0, 0);
    @(negedge clk);
    chk("win_state", 32'(bus_if.state_o), 5);
    chk("win_correct", 32'(bus_if.correct_led), 1);
    chk("win_leds", 32'(bus_if.leds), 32'hF);
    chk("win_level", 32'(bus_if.level), MAXL);
    ack(0, "win_ack");

    // mismatched one-hot at round 2, idx 1
    begin_game(1);
    run_game(2, 1, 0, 1);
    @(negedge clk);
    chk("wrong_state", 32'(bus_if.state_o), 6);
    chk("wrong_led", 32'(bus_if.wrong_led), 1);
    chk("wrong_leds", 32'(bus_if.leds), 0);
    chk("wrong_level", 32'(bus_if.level), 2);
    ack(1, "lose_ack");

    // multi-hot press
    begin_game(2);
    run_game(1, 0, 1, 0);
    @(negedge clk); chk("multihot_state", 32'(bus_if.state_o), 6);
    ack(0, "mh_ack");

    // timeout
    begin_game(0);
    run_game(2, 0, 2, 1);
    @(negedge clk); chk("timeout_state", 32'(bus_if.state_o), 6);
    ack(0, "to_ack");

    // correct press coincident with the timeout tick, in every slot of round 2
    begin_game(0);
    run_game(2, 0, 3, 0);
    @(negedge clk); chk("coincident_win", 32'(bus_if.state_o), 5);
    ack(1, "co_ack");

    // mid-game reset during SHOW_ON
    begin_game(0);
    n = 0;
    while (m_state != 2 && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_show", 32'(bus_if.state_o), 2);
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(bus_if.state_o), 0);
    chk("mid_rst_level", 32'(bus_if.level), 0);
    chk("mid_rst_leds", 32'(bus_if.leds), 32'hF);
    chk("mid_rst_lfsr", 32'(dut.lfsr_q), 32'hA5);

    // randomized games
    for (int g = 0; g < 8; g++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      begin_game(int'($urandom_range(0, 2)));
      kind = int'($urandom_range(0, 3));
      run_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), kind, 1);
      ack(1'($urandom_range(0, 1)), "rnd_ack");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
endmodule
